// File: rtl/axi4s_div_arbiter.sv
// Shares one AXI4-Stream long divider among several clock-enable frequency
// generators. Requests (dividend beat, then divisor beat with tlast) are
// granted round-robin and forwarded with the client index as tid; divider
// responses are routed back to the client named by their tid.
module axi4s_div_arbiter #(
   parameter int unsigned AXI_DATA_WIDTH_P = 32,
   parameter int unsigned AXI_ID_WIDTH_P   = 2,
   parameter int unsigned NR_OF_CLIENTS_P  = 4,
   parameter int unsigned TIMEOUT_P        = 1024
) (
   input  logic                                        clk,
   input  logic                                        rst,
   // Client request streams
   input  logic [NR_OF_CLIENTS_P-1:0]                  cli_ing_tvalid,
   output logic [NR_OF_CLIENTS_P-1:0]                  cli_ing_tready,
   input  logic [NR_OF_CLIENTS_P-1:0]                  cli_ing_tlast,
   input  logic [NR_OF_CLIENTS_P*AXI_DATA_WIDTH_P-1:0] cli_ing_tdata,
   // Request stream towards the divider
   output logic                                        div_egr_tvalid,
   input  logic                                        div_egr_tready,
   output logic [AXI_DATA_WIDTH_P-1:0]                 div_egr_tdata,
   output logic                                        div_egr_tlast,
   output logic [AXI_ID_WIDTH_P-1:0]                   div_egr_tid,
   // Divider response stream (no backpressure)
   input  logic                                        div_ing_tvalid,
   input  logic [AXI_DATA_WIDTH_P-1:0]                 div_ing_tdata,
   input  logic                                        div_ing_tlast,
   input  logic [AXI_ID_WIDTH_P-1:0]                   div_ing_tid,
   input  logic                                        div_ing_tuser,
   // Client response: one-hot valid, broadcast payload
   output logic [NR_OF_CLIENTS_P-1:0]                  cli_egr_tvalid,
   output logic [AXI_DATA_WIDTH_P-1:0]                 cli_egr_tdata,
   output logic                                        cli_egr_tlast,
   output logic                                        cli_egr_tuser,
   // Status
   output logic                                        sr_timeout,
   output logic [7:0]                                  sr_dropped
);

   localparam int unsigned W    = AXI_DATA_WIDTH_P;
   localparam int unsigned IdW  = AXI_ID_WIDTH_P;
   localparam int unsigned Nr   = NR_OF_CLIENTS_P;
   localparam int unsigned CntW = (TIMEOUT_P > 1) ? $clog2(TIMEOUT_P) : 1;

   // Every client index must be expressible as a tid.
   if (NR_OF_CLIENTS_P > (2 ** AXI_ID_WIDTH_P)) begin : g_bad_params
      $error("NR_OF_CLIENTS_P exceeds the tid range");
   end

   typedef enum logic [1:0] {
      IDLE_E,
      FORWARD_E,
      WAIT_E
   } state_t;

   state_t           state_q, state_d;
   logic [IdW-1:0]   grant_q, grant_d;
   logic [IdW-1:0]   rr_ptr_q, rr_ptr_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic             timeout_q, timeout_d;

   logic [Nr-1:0]    resp_vld_q;
   logic [W-1:0]     resp_data_q;
   logic             resp_last_q;
   logic             resp_user_q;
   logic [7:0]       dropped_q;

   logic [IdW-1:0]   arb_hi_pick, arb_lo_pick, arb_pick;
   logic             arb_hi_found;

   logic             sel_valid;
   logic             sel_last;
   logic [W-1:0]     sel_data;

   logic [Nr-1:0]    resp_hit;

   // Round-robin pick: lowest valid index at or after rr_ptr, else lowest valid overall.
   always_comb begin
      arb_hi_pick  = '0;
      arb_lo_pick  = '0;
      arb_hi_found = 1'b0;
      // Descending scan so the lowest qualifying index is the one that sticks.
      for (int i = int'(Nr) - 1; i >= 0; i--) begin
         if (cli_ing_tvalid[i]) begin
            arb_lo_pick = IdW'(i);
            if (IdW'(i) >= rr_ptr_q) begin
               arb_hi_pick  = IdW'(i);
               arb_hi_found = 1'b1;
            end
         end
      end
      arb_pick = arb_hi_found ? arb_hi_pick : arb_lo_pick;
   end

   // Mux the granted client's request signals.
   always_comb begin
      sel_valid = 1'b0;
      sel_last  = 1'b0;
      sel_data  = '0;
      for (int i = 0; i < int'(Nr); i++) begin
         if (grant_q == IdW'(i)) begin
            sel_valid = cli_ing_tvalid[i];
            sel_last  = cli_ing_tlast[i];
            sel_data  = cli_ing_tdata[i*W +: W];
         end
      end
   end

   // Arbitration FSM: next state, grant bookkeeping and request-path outputs.
   always_comb begin
      state_d        = state_q;
      grant_d        = grant_q;
      rr_ptr_d       = rr_ptr_q;
      cnt_d          = cnt_q;
      timeout_d      = timeout_q;
      div_egr_tvalid = 1'b0;
      div_egr_tdata  = sel_data;
      div_egr_tlast  = sel_last;
      div_egr_tid    = grant_q;
      cli_ing_tready = '0;

      unique case (state_q)
         IDLE_E: begin
            if (|cli_ing_tvalid) begin
               grant_d = arb_pick;
               state_d = FORWARD_E;
            end
         end

         FORWARD_E: begin
            // Grant is held until the tlast beat; other clients simply wait.
            div_egr_tvalid = sel_valid;
            for (int i = 0; i < int'(Nr); i++) begin
               if (grant_q == IdW'(i)) begin
                  cli_ing_tready[i] = div_egr_tready;
               end
            end
            if (sel_valid && div_egr_tready && sel_last) begin
               state_d  = WAIT_E;
               cnt_d    = '0;
               rr_ptr_d = (grant_q == IdW'(Nr - 1)) ? '0 : grant_q + 1'b1;
            end
         end

         WAIT_E: begin
            cnt_d = cnt_q + 1'b1;
            if (div_ing_tvalid && div_ing_tlast) begin
               state_d = IDLE_E;
            end else if (cnt_q == CntW'(TIMEOUT_P - 1)) begin
               state_d   = IDLE_E;
               timeout_d = 1'b1;
            end
         end

         default: begin
            state_d = IDLE_E;
         end
      endcase
   end

   // FSM and arbitration state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE_E;
         grant_q   <= '0;
         rr_ptr_q  <= '0;
         cnt_q     <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         rr_ptr_q  <= rr_ptr_d;
         cnt_q     <= cnt_d;
         timeout_q <= timeout_d;
      end
   end

   // Decode response tid to a client one-hot; all-zero means out of range.
   always_comb begin
      resp_hit = '0;
      for (int i = 0; i < int'(Nr); i++) begin
         if (div_ing_tid == IdW'(i)) begin
            resp_hit[i] = 1'b1;
         end
      end
   end

   // Response path runs independently of the FSM, so late responses still route.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         resp_vld_q  <= '0;
         resp_data_q <= '0;
         resp_last_q <= 1'b0;
         resp_user_q <= 1'b0;
         dropped_q   <= '0;
      end else begin
         resp_vld_q <= div_ing_tvalid ? resp_hit : '0;
         if (div_ing_tvalid) begin
            resp_data_q <= div_ing_tdata;
            resp_last_q <= div_ing_tlast;
            resp_user_q <= div_ing_tuser;
         end
         if (div_ing_tvalid && (resp_hit == '0) && (dropped_q != 8'hFF)) begin
            dropped_q <= dropped_q + 8'd1;
         end
      end
   end

   assign cli_egr_tvalid = resp_vld_q;
   assign cli_egr_tdata  = resp_data_q;
   assign cli_egr_tlast  = resp_last_q;
   assign cli_egr_tuser  = resp_user_q;
   assign sr_timeout     = timeout_q;
   assign sr_dropped     = dropped_q;

endmodule

// File: tb/tb_axi4s_div_arbiter.sv
// Directed bench for axi4s_div_arbiter: a 4-client instance (TIMEOUT_P = 16)
// for arbitration, backpressure, timeout and reset, and a 3-client instance
// for out-of-range tid handling.
module tb_axi4s_div_arbiter;

   logic         clk;
   logic         rst;

   logic [3:0]   cli_ing_tvalid, cli_ing_tready, cli_ing_tlast;
   logic [127:0] cli_ing_tdata;
   logic         div_egr_tvalid, div_egr_tready, div_egr_tlast;
   logic [31:0]  div_egr_tdata;
   logic [1:0]   div_egr_tid;
   logic         div_ing_tvalid, div_ing_tlast, div_ing_tuser;
   logic [31:0]  div_ing_tdata;
   logic [1:0]   div_ing_tid;
   logic [3:0]   cli_egr_tvalid;
   logic [31:0]  cli_egr_tdata;
   logic         cli_egr_tlast, cli_egr_tuser;
   logic         sr_timeout;
   logic [7:0]   sr_dropped;

   logic [2:0]   d3_cli_ing_tvalid, d3_cli_ing_tready, d3_cli_ing_tlast;
   logic [95:0]  d3_cli_ing_tdata;
   logic         d3_div_egr_tvalid, d3_div_egr_tready, d3_div_egr_tlast;
   logic [31:0]  d3_div_egr_tdata;
   logic [1:0]   d3_div_egr_tid;
   logic         d3_div_ing_tvalid, d3_div_ing_tlast, d3_div_ing_tuser;
   logic [31:0]  d3_div_ing_tdata;
   logic [1:0]   d3_div_ing_tid;
   logic [2:0]   d3_cli_egr_tvalid;
   logic [31:0]  d3_cli_egr_tdata;
   logic         d3_cli_egr_tlast, d3_cli_egr_tuser;
   logic         d3_sr_timeout;
   logic [7:0]   d3_sr_dropped;

   int n_checks = 0;
   int n_fail   = 0;

   // Client / divider behavioural model state
   bit [3:0]     cl_active, cl_beat, hs;
   bit           cl_rearm, egr_ready, auto_resp, resp_due, man_valid;
   logic [31:0]  cl_a [4];
   logic [31:0]  cl_b [4];
   int           cl_done [4];
   logic [1:0]   resp_tid, man_tid;
   logic [31:0]  man_data;
   logic         man_user;
   int           order [$];
   int           proto_err;
   int           last_cli;

   axi4s_div_arbiter #(
      .AXI_DATA_WIDTH_P (32),
      .AXI_ID_WIDTH_P   (2),
      .NR_OF_CLIENTS_P  (4),
      .TIMEOUT_P        (16)
   ) u_dut (
      .clk            (clk),
      .rst            (rst),
      .cli_ing_tvalid (cli_ing_tvalid),
      .cli_ing_tready (cli_ing_tready),
      .cli_ing_tlast  (cli_ing_tlast),
      .cli_ing_tdata  (cli_ing_tdata),
      .div_egr_tvalid (div_egr_tvalid),
      .div_egr_tready (div_egr_tready),
      .div_egr_tdata  (div_egr_tdata),
      .div_egr_tlast  (div_egr_tlast),
      .div_egr_tid    (div_egr_tid),
      .div_ing_tvalid (div_ing_tvalid),
      .div_ing_tdata  (div_ing_tdata),
      .div_ing_tlast  (div_ing_tlast),
      .div_ing_tid    (div_ing_tid),
      .div_ing_tuser  (div_ing_tuser),
      .cli_egr_tvalid (cli_egr_tvalid),
      .cli_egr_tdata  (cli_egr_tdata),
      .cli_egr_tlast  (cli_egr_tlast),
      .cli_egr_tuser  (cli_egr_tuser),
      .sr_timeout     (sr_timeout),
      .sr_dropped     (sr_dropped)
   );

   axi4s_div_arbiter #(
      .AXI_DATA_WIDTH_P (32),
      .AXI_ID_WIDTH_P   (2),
      .NR_OF_CLIENTS_P  (3),
      .TIMEOUT_P        (16)
   ) u_dut3 (
      .clk            (clk),
      .rst            (rst),
      .cli_ing_tvalid (d3_cli_ing_tvalid),
      .cli_ing_tready (d3_cli_ing_tready),
      .cli_ing_tlast  (d3_cli_ing_tlast),
      .cli_ing_tdata  (d3_cli_ing_tdata),
      .div_egr_tvalid (d3_div_egr_tvalid),
      .div_egr_tready (d3_div_egr_tready),
      .div_egr_tdata  (d3_div_egr_tdata),
      .div_egr_tlast  (d3_div_egr_tlast),
      .div_egr_tid    (d3_div_egr_tid),
      .div_ing_tvalid (d3_div_ing_tvalid),
      .div_ing_tdata  (d3_div_ing_tdata),
      .div_ing_tlast  (d3_div_ing_tlast),
      .div_ing_tid    (d3_div_ing_tid),
      .div_ing_tuser  (d3_div_ing_tuser),
      .cli_egr_tvalid (d3_cli_egr_tvalid),
      .cli_egr_tdata  (d3_cli_egr_tdata),
      .cli_egr_tlast  (d3_cli_egr_tlast),
      .cli_egr_tuser  (d3_cli_egr_tuser),
      .sr_timeout     (d3_sr_timeout),
      .sr_dropped     (d3_sr_dropped)
   );

   always #5 clk = ~clk;

   task automatic drive_clients();
      for (int i = 0; i < 4; i++) begin
         cli_ing_tvalid[i]         = cl_active[i];
         cli_ing_tlast[i]          = cl_beat[i];
         cli_ing_tdata[i*32 +: 32] = cl_beat[i] ? cl_b[i] : cl_a[i];
      end
      div_egr_tready = egr_ready;
   endtask

   task automatic clear_model();
      cl_active = '0;
      cl_beat   = '0;
      hs        = '0;
      resp_due  = 1'b0;
      man_valid = 1'b0;
      cl_rearm  = 1'b0;
      auto_resp = 1'b0;
      egr_ready = 1'b1;
      proto_err = 0;
      last_cli  = -1;
      order.delete();
      for (int i = 0; i < 4; i++) cl_done[i] = 0;
   endtask

   // One cycle: advance the client model on last handshake, drive, then sample.
   task automatic step();
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         if (hs[i]) begin
            if (!cl_beat[i]) begin
               cl_beat[i] = 1'b1;
            end else begin
               cl_beat[i] = 1'b0;
               cl_done[i]++;
               if (!cl_rearm) cl_active[i] = 1'b0;
            end
         end
      end
      drive_clients();
      div_ing_tvalid = 1'b0;
      if (resp_due) begin
         div_ing_tvalid = 1'b1;
         div_ing_tid    = resp_tid;
         div_ing_tdata  = 32'd160 + 32'(resp_tid);
         div_ing_tlast  = 1'b1;
         div_ing_tuser  = 1'b0;
         resp_due       = 1'b0;
      end else if (man_valid) begin
         div_ing_tvalid = 1'b1;
         div_ing_tid    = man_tid;
         div_ing_tdata  = man_data;
         div_ing_tlast  = 1'b1;
         div_ing_tuser  = man_user;
         man_valid      = 1'b0;
      end
      #1;
      hs = cli_ing_tvalid & cli_ing_tready;
      if ($countones(hs) > 1) proto_err++;
      for (int i = 0; i < 4; i++) begin
         if (hs[i]) begin
            if (!div_egr_tvalid || div_egr_tid != 2'(i)) proto_err++;
            if (!cl_beat[i]) begin
               order.push_back(i);
               if (div_egr_tdata != cl_a[i] || div_egr_tlast) proto_err++;
               last_cli = i;
            end else if (last_cli != i || div_egr_tdata != cl_b[i] || !div_egr_tlast) begin
               proto_err++;
            end
         end
      end
      if (auto_resp && div_egr_tvalid && div_egr_tready && div_egr_tlast) begin
         resp_due = 1'b1;
         resp_tid = div_egr_tid;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      clear_model();
      drive_clients();
      div_ing_tvalid = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst            = 1'b1;
      cli_ing_tvalid = 4'hF;
      div_egr_tready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      #1;
      n_checks++; if (div_egr_tvalid !== 1'b0) begin n_fail++;
         $display("FAIL rst_div_egr_tvalid: got %0b want 0", div_egr_tvalid); end
      n_checks++; if (cli_ing_tready !== 4'h0) begin n_fail++;
         $display("FAIL rst_cli_ing_tready: got %0h want 0", cli_ing_tready); end
      n_checks++; if (cli_egr_tvalid !== 4'h0) begin n_fail++;
         $display("FAIL rst_cli_egr_tvalid: got %0h want 0", cli_egr_tvalid); end
      n_checks++; if (cli_egr_tdata !== 32'h0 || cli_egr_tlast !== 1'b0 || cli_egr_tuser !== 1'b0)
         begin n_fail++; $display("FAIL rst_payload: got %0h/%0b/%0b want 0/0/0",
            cli_egr_tdata, cli_egr_tlast, cli_egr_tuser); end
      n_checks++; if (sr_timeout !== 1'b0 || sr_dropped !== 8'd0) begin n_fail++;
         $display("FAIL rst_status: got %0b/%0d want 0/0", sr_timeout, sr_dropped); end
      do_reset();
   endtask

   task automatic test_dropped();
      @(negedge clk);
      d3_div_ing_tvalid = 1'b1; d3_div_ing_tid = 2'd3; d3_div_ing_tdata = 32'd7;
      d3_div_ing_tlast  = 1'b1; d3_div_ing_tuser = 1'b0;
      @(negedge clk);
      d3_div_ing_tvalid = 1'b0;
      #1;
      n_checks++; if (d3_cli_egr_tvalid !== 3'b000) begin n_fail++;
         $display("FAIL drop_no_valid: got %0b want 000", d3_cli_egr_tvalid); end
      n_checks++; if (d3_sr_dropped !== 8'd1) begin n_fail++;
         $display("FAIL drop_count: got %0d want 1", d3_sr_dropped); end
      @(negedge clk);
      d3_div_ing_tvalid = 1'b1; d3_div_ing_tid = 2'd2; d3_div_ing_tdata = 32'd9;
      @(negedge clk);
      d3_div_ing_tvalid = 1'b0;
      #1;
      n_checks++; if (d3_cli_egr_tvalid !== 3'b100 || d3_cli_egr_tdata !== 32'd9) begin n_fail++;
         $display("FAIL drop_inrange: got %0b/%0d want 100/9", d3_cli_egr_tvalid, d3_cli_egr_tdata);
      end
      @(negedge clk);
      d3_div_ing_tvalid = 1'b1; d3_div_ing_tid = 2'd3;
      repeat (300) @(negedge clk);
      d3_div_ing_tvalid = 1'b0;
      #1;
      n_checks++; if (d3_sr_dropped !== 8'd255) begin n_fail++;
         $display("FAIL drop_saturate: got %0d want 255", d3_sr_dropped); end
   endtask

   task automatic test_single();
      do_reset();
      cl_a[2] = 32'd100000000; cl_b[2] = 32'd10000000; cl_active[2] = 1'b1;
      step();
      n_checks++; if (div_egr_tvalid !== 1'b0 || cli_ing_tready !== 4'h0) begin n_fail++;
         $display("FAIL single_idle: got %0b/%0h want 0/0", div_egr_tvalid, cli_ing_tready); end
      step();
      n_checks++; if (div_egr_tvalid !== 1'b1 || div_egr_tid !== 2'd2 ||
                      div_egr_tdata !== 32'd100000000 || div_egr_tlast !== 1'b0) begin n_fail++;
         $display("FAIL single_beat0: got v%0b id%0d d%0d l%0b want v1 id2 d100000000 l0",
            div_egr_tvalid, div_egr_tid, div_egr_tdata, div_egr_tlast); end
      n_checks++; if (cli_ing_tready !== 4'b0100) begin n_fail++;
         $display("FAIL single_ready: got %0b want 0100", cli_ing_tready); end
      step();
      n_checks++; if (div_egr_tdata !== 32'd10000000 || div_egr_tlast !== 1'b1) begin n_fail++;
         $display("FAIL single_beat1: got d%0d l%0b want d10000000 l1", div_egr_tdata,
            div_egr_tlast); end
      step();
      n_checks++; if (div_egr_tvalid !== 1'b0 || cli_ing_tready !== 4'h0) begin n_fail++;
         $display("FAIL single_wait: got %0b/%0h want 0/0", div_egr_tvalid, cli_ing_tready); end
      man_valid = 1'b1; man_tid = 2'd2; man_data = 32'd160; man_user = 1'b0;
      step();
      n_checks++; if (cli_egr_tvalid !== 4'h0) begin n_fail++;
         $display("FAIL single_latency: got %0b want 0000", cli_egr_tvalid); end
      step();
      n_checks++; if (cli_egr_tvalid !== 4'b0100 || cli_egr_tdata !== 32'd160 ||
                      cli_egr_tlast !== 1'b1 || cli_egr_tuser !== 1'b0) begin n_fail++;
         $display("FAIL single_resp: got v%0b d%0d l%0b u%0b want v0100 d160 l1 u0",
            cli_egr_tvalid, cli_egr_tdata, cli_egr_tlast, cli_egr_tuser); end
      step();
      n_checks++; if (cli_egr_tvalid !== 4'h0) begin n_fail++;
         $display("FAIL single_resp_pulse: got %0b want 0000", cli_egr_tvalid); end
   endtask

   task automatic test_round_robin();
      int exp_order [5] = '{0, 1, 2, 3, 0};
      int n;
      do_reset();
      auto_resp = 1'b1;
      cl_rearm  = 1'b1;
      for (int i = 0; i < 4; i++) begin
         cl_a[i] = 32'(i * 16 + 1); cl_b[i] = 32'(i * 16 + 2); cl_active[i] = 1'b1;
      end
      n = 0;
      while (order.size() < 5 && n < 200) begin step(); n++; end
      n_checks++; if (order.size() < 5) begin n_fail++;
         $display("FAIL rr_progress: got %0d grants want 5", order.size()); end
      for (int k = 0; k < 5; k++) begin
         if (k < order.size()) begin
            n_checks++; if (order[k] != exp_order[k]) begin n_fail++;
               $display("FAIL rr_order[%0d]: got %0d want %0d", k, order[k], exp_order[k]); end
         end
      end
      n_checks++; if (proto_err != 0) begin n_fail++;
         $display("FAIL rr_contiguous: got %0d protocol errors want 0", proto_err); end
      n_checks++; if (sr_timeout !== 1'b0) begin n_fail++;
         $display("FAIL rr_no_timeout: got %0b want 0", sr_timeout); end
   endtask

   task automatic test_backpressure();
      int n;
      do_reset();
      auto_resp = 1'b1;
      egr_ready = 1'b0;
      cl_a[1] = 32'h1111; cl_b[1] = 32'h1112; cl_active[1] = 1'b1;
      cl_a[2] = 32'h2221; cl_b[2] = 32'h2222; cl_active[2] = 1'b1;
      n = 0;
      do begin step(); n++; end while (!div_egr_tvalid && n < 10);
      for (int k = 0; k < 5; k++) begin
         n_checks++; if (div_egr_tvalid !== 1'b1 || div_egr_tid !== 2'd1 ||
                         div_egr_tdata !== 32'h1111 || div_egr_tlast !== 1'b0) begin n_fail++;
            $display("FAIL bp_hold[%0d]: got v%0b id%0d d%0h want v1 id1 d1111", k,
               div_egr_tvalid, div_egr_tid, div_egr_tdata); end
         n_checks++; if (cli_ing_tready !== 4'h0) begin n_fail++;
            $display("FAIL bp_ready[%0d]: got %0b want 0000", k, cli_ing_tready); end
         step();
      end
      egr_ready = 1'b1;
      n = 0;
      while ((cl_done[1] == 0 || cl_done[2] == 0) && n < 60) begin step(); n++; end
      n_checks++; if (order.size() != 2 || order[0] != 1 || order[1] != 2) begin n_fail++;
         $display("FAIL bp_order: got %0d grants first %0d want 2 grants 1,2", order.size(),
            (order.size() > 0) ? order[0] : -1); end
      n_checks++; if (proto_err != 0) begin n_fail++;
         $display("FAIL bp_protocol: got %0d errors want 0", proto_err); end
   endtask

   task automatic test_timeout();
      int n;
      int bad;
      do_reset();
      cl_a[0] = 32'd50; cl_b[0] = 32'd5; cl_active[0] = 1'b1;
      cl_a[1] = 32'd60; cl_b[1] = 32'd6; cl_active[1] = 1'b1;
      n = 0;
      do begin step(); n++; end while (!(hs[0] && cl_beat[0]) && n < 20);
      bad = 0;
      for (int k = 0; k < 16; k++) begin
         step();
         if (div_egr_tvalid !== 1'b0 || sr_timeout !== 1'b0) bad++;
      end
      n_checks++; if (bad != 0) begin n_fail++;
         $display("FAIL to_wait: got %0d bad WAIT cycles want 0", bad); end
      egr_ready = 1'b0;
      step();
      n_checks++; if (sr_timeout !== 1'b1 || div_egr_tvalid !== 1'b0) begin n_fail++;
         $display("FAIL to_sticky: got to%0b v%0b want to1 v0", sr_timeout, div_egr_tvalid); end
      step();
      n_checks++; if (div_egr_tvalid !== 1'b1 || div_egr_tid !== 2'd1) begin n_fail++;
         $display("FAIL to_next_grant: got v%0b id%0d want v1 id1", div_egr_tvalid, div_egr_tid);
      end
      // Late response for client 0 while client 1 is being forwarded.
      man_valid = 1'b1; man_tid = 2'd0; man_data = 32'h55; man_user = 1'b1;
      step();
      step();
      n_checks++; if (cli_egr_tvalid !== 4'b0001 || cli_egr_tuser !== 1'b1 ||
                      cli_egr_tdata !== 32'h55) begin n_fail++;
         $display("FAIL to_late_route: got v%0b u%0b d%0h want v0001 u1 d55", cli_egr_tvalid,
            cli_egr_tuser, cli_egr_tdata); end
      n_checks++; if (div_egr_tvalid !== 1'b1 || div_egr_tid !== 2'd1) begin n_fail++;
         $display("FAIL to_late_fsm: got v%0b id%0d want v1 id1", div_egr_tvalid, div_egr_tid); end
      egr_ready = 1'b1;
      auto_resp = 1'b1;
      n = 0;
      while (cl_done[1] == 0 && n < 40) begin step(); n++; end
      n_checks++; if (cl_done[1] != 1) begin n_fail++;
         $display("FAIL to_client1_done: got %0d want 1", cl_done[1]); end
      step();
      step();
   endtask

   task automatic test_reset_mid();
      int n;
      auto_resp = 1'b0;
      cl_a[3] = 32'd70; cl_b[3] = 32'd7; cl_active[3] = 1'b1;
      cl_a[0] = 32'd80; cl_b[0] = 32'd8;
      n = 0;
      do begin step(); n++; end while (!(hs[3] && !cl_beat[3]) && n < 20);
      man_valid = 1'b1; man_tid = 2'd3; man_data = 32'hAB; man_user = 1'b0;
      step();
      rst = 1'b1;
      #1;
      n_checks++; if (div_egr_tvalid !== 1'b0 || cli_ing_tready !== 4'h0) begin n_fail++;
         $display("FAIL rmid_req: got v%0b r%0h want v0 r0", div_egr_tvalid, cli_ing_tready); end
      n_checks++; if (cli_egr_tvalid !== 4'h0 || cli_egr_tdata !== 32'h0) begin n_fail++;
         $display("FAIL rmid_resp: got v%0b d%0h want v0 d0", cli_egr_tvalid, cli_egr_tdata); end
      n_checks++; if (sr_timeout !== 1'b0 || sr_dropped !== 8'd0) begin n_fail++;
         $display("FAIL rmid_status: got %0b/%0d want 0/0", sr_timeout, sr_dropped); end
      clear_model();
      cl_active[0] = 1'b1;
      cl_active[3] = 1'b1;
      auto_resp    = 1'b1;
      @(negedge clk);
      rst            = 1'b0;
      div_ing_tvalid = 1'b0;
      drive_clients();
      step();
      n_checks++; if (cli_egr_tvalid !== 4'h0) begin n_fail++;
         $display("FAIL rmid_no_stale: got %0b want 0000", cli_egr_tvalid); end
      n = 0;
      while (order.size() < 1 && n < 20) begin step(); n++; end
      n_checks++; if (order.size() < 1 || order[0] != 0) begin n_fail++;
         $display("FAIL rmid_first_grant: got %0d want 0", (order.size() > 0) ? order[0] : -1);
      end
   endtask

   initial begin
      clk = 1'b0;
      rst = 1'b1;
      cli_ing_tvalid = '0; cli_ing_tlast = '0; cli_ing_tdata = '0;
      div_egr_tready = 1'b1;
      div_ing_tvalid = 1'b0; div_ing_tdata = '0; div_ing_tlast = 1'b0;
      div_ing_tid = '0; div_ing_tuser = 1'b0;
      d3_cli_ing_tvalid = '0; d3_cli_ing_tlast = '0; d3_cli_ing_tdata = '0;
      d3_div_egr_tready = 1'b1;
      d3_div_ing_tvalid = 1'b0; d3_div_ing_tdata = '0; d3_div_ing_tlast = 1'b0;
      d3_div_ing_tid = '0; d3_div_ing_tuser = 1'b0;
      resp_tid = '0; man_tid = '0; man_data = '0; man_user = 1'b0;
      for (int i = 0; i < 4; i++) begin cl_a[i] = '0; cl_b[i] = '0; end
      clear_model();

      test_reset();
      test_dropped();
      test_single();
      test_round_robin();
      test_backpressure();
      test_timeout();
      test_reset_mid();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, got timeout want finish");
      $fatal(1, "watchdog expired");
   end

endmodule
